// File: rtl/ibex_pkg.sv
// PMP CSR types, mode encodings and CSR address map.
// Shared by the CSR file, its write filter and the PMP checker.
package ibex_pkg;

  typedef enum logic [1:0] {
    PMP_MODE_OFF   = 2'b00,
    PMP_MODE_TOR   = 2'b01,
    PMP_MODE_NA4   = 2'b10,
    PMP_MODE_NAPOT = 2'b11
  } pmp_cfg_mode_e;

  typedef struct packed {
    logic          lock;
    pmp_cfg_mode_e mode;
    logic          exec;
    logic          write;
    logic          read;
  } pmp_cfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } pmp_mseccfg_t;

  localparam logic [11:0] CSR_PMPCFG0   = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR0  = 12'h3B0;
  localparam logic [11:0] CSR_MSECCFG   = 12'h747;
  localparam logic [11:0] CSR_MSECCFGH  = 12'h757;
  localparam int          PMP_MAX_REGIONS = 16;

  // Architectural byte layout: L at bit 7, bits 6:5 hardwired to zero.
  function automatic logic [7:0] pmp_cfg_to_byte(pmp_cfg_t c);
    return {c.lock, 2'b00, c.mode, c.exec, c.write, c.read};
  endfunction

  function automatic pmp_cfg_t pmp_byte_to_cfg(logic [7:0] b);
    pmp_cfg_t c;
    c.lock  = b[7];
    c.mode  = pmp_cfg_mode_e'(b[4:3]);
    c.exec  = b[2];
    c.write = b[1];
    c.read  = b[0];
    return c;
  endfunction

endpackage

// File: rtl/ibex_pmp_cfg_wrfilter.sv
// Purpose: legalises one pmpcfg byte write against lock and MML rules.
// Latency: combinational. Backpressure: none, a rejected write is silently dropped.
module ibex_pmp_cfg_wrfilter
  import ibex_pkg::*;
#(
  parameter int PMPGranularity = 0
) (
  input  logic       wr_en,
  input  logic [7:0] wr_byte,
  input  pmp_cfg_t   cfg_q,
  input  logic       mml,
  input  logic       rlb,
  output logic       cfg_we,
  output pmp_cfg_t   cfg_d
);

  pmp_cfg_t wr_cfg;
  logic     locked;
  logic     mml_illegal;

  assign wr_cfg = pmp_byte_to_cfg(wr_byte);

  always_comb begin
    cfg_d = wr_cfg;
    // R=0,W=1 is reserved outside machine-mode lockdown.
    if (!mml && !wr_cfg.read && wr_cfg.write) begin
      cfg_d.write = 1'b0;
    end
    if (PMPGranularity >= 1 && wr_cfg.mode == PMP_MODE_NA4) begin
      cfg_d.mode = cfg_q.mode;
    end
  end

  assign locked      = cfg_q.lock & ~rlb;
  assign mml_illegal = mml & ~rlb & wr_cfg.lock &
                       ((~wr_cfg.read & wr_cfg.write) |
                        (wr_cfg.exec & ~(wr_cfg.read & wr_cfg.write)));
  assign cfg_we      = wr_en & ~locked & ~mml_illegal;

endmodule

// File: rtl/ibex_pmp_csr.sv
// Purpose: PMP CSR file (pmpcfg, pmpaddr, mseccfg) feeding the PMP checker.
// Latency: reads combinational, writes visible on outputs one cycle later. Backpressure: none.
module ibex_pmp_csr
  import ibex_pkg::*;
#(
  parameter int PMPNumRegions  = 4,
  parameter int PMPGranularity = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         csr_access_i,
  input  logic         csr_we_i,
  input  logic [11:0]  csr_addr_i,
  input  logic [31:0]  csr_wdata_i,
  output logic [31:0]  csr_rdata_o,
  output logic         csr_hit_o,
  output pmp_cfg_t     csr_pmp_cfg_o [PMPNumRegions],
  output logic [33:0]  csr_pmp_addr_o [PMPNumRegions],
  output pmp_mseccfg_t csr_pmp_mseccfg_o
);

  pmp_cfg_t                 cfg_q   [PMPNumRegions];
  logic [7:0]               cfg_rd  [PMP_MAX_REGIONS];
  logic [31:0]              addr_rd [PMP_MAX_REGIONS];
  logic [PMPNumRegions-1:0] lock_vec;
  pmp_mseccfg_t             mseccfg_q;
  logic                     wr;
  logic                     cfg_hit;
  logic                     addr_hit;

  assign cfg_hit   = csr_addr_i[11:2] == CSR_PMPCFG0[11:2];
  assign addr_hit  = csr_addr_i[11:4] == CSR_PMPADDR0[11:4];
  assign csr_hit_o = cfg_hit | addr_hit | (csr_addr_i == CSR_MSECCFG) |
                     (csr_addr_i == CSR_MSECCFGH);
  assign wr        = csr_access_i & csr_we_i & ~rst_i;

  for (genvar r = 0; r < PMP_MAX_REGIONS; r++) begin : g_regions
    if (r < PMPNumRegions) begin : g_impl
      localparam logic [11:0] CfgAddr  = CSR_PMPCFG0 + 12'(r / 4);
      localparam logic [11:0] AddrAddr = CSR_PMPADDR0 + 12'(r);

      pmp_cfg_t    cfg_r;
      pmp_cfg_t    cfg_d;
      logic        cfg_we;
      logic [31:0] addr_r;
      logic [31:0] addr_rd_v;
      logic        addr_locked;

      ibex_pmp_cfg_wrfilter #(
        .PMPGranularity(PMPGranularity)
      ) u_wrfilter (
        .wr_en  (wr && csr_addr_i == CfgAddr),
        .wr_byte(csr_wdata_i[8*(r%4) +: 8]),
        .cfg_q  (cfg_r),
        .mml    (mseccfg_q.mml),
        .rlb    (mseccfg_q.rlb),
        .cfg_we (cfg_we),
        .cfg_d  (cfg_d)
      );

      // A locked TOR region above also freezes this region's address (its base).
      if (r + 1 < PMPNumRegions) begin : g_tor
        assign addr_locked = ~mseccfg_q.rlb &
                             (cfg_r.lock | (cfg_q[r+1].mode == PMP_MODE_TOR & cfg_q[r+1].lock));
      end else begin : g_top
        assign addr_locked = ~mseccfg_q.rlb & cfg_r.lock;
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cfg_r  <= '0;
          addr_r <= '0;
        end else begin
          if (cfg_we) begin
            cfg_r <= cfg_d;
          end
          if (wr && csr_addr_i == AddrAddr && !addr_locked) begin
            addr_r <= csr_wdata_i;
          end
        end
      end

      always_comb begin
        addr_rd_v = addr_r;
        for (int b = 0; b < 32; b++) begin
          if (cfg_r.mode == PMP_MODE_NAPOT && b < PMPGranularity - 1) begin
            addr_rd_v[b] = 1'b1;
          end
          if ((cfg_r.mode == PMP_MODE_OFF || cfg_r.mode == PMP_MODE_TOR) && b < PMPGranularity) begin
            addr_rd_v[b] = 1'b0;
          end
        end
      end

      assign cfg_q[r]          = cfg_r;
      assign lock_vec[r]       = cfg_r.lock;
      assign cfg_rd[r]         = pmp_cfg_to_byte(cfg_r);
      assign addr_rd[r]        = addr_rd_v;
      assign csr_pmp_cfg_o[r]  = cfg_r;
      assign csr_pmp_addr_o[r] = {addr_r, 2'b00};
    end else begin : g_unimpl
      assign cfg_rd[r]  = '0;
      assign addr_rd[r] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mseccfg_q <= '0;
    end else if (wr && csr_addr_i == CSR_MSECCFG) begin
      mseccfg_q.mml  <= mseccfg_q.mml | csr_wdata_i[0];
      mseccfg_q.mmwp <= mseccfg_q.mmwp | csr_wdata_i[1];
      mseccfg_q.rlb  <= csr_wdata_i[2] & (mseccfg_q.rlb | ~|lock_vec);
    end
  end

  assign csr_pmp_mseccfg_o = mseccfg_q;

  always_comb begin
    csr_rdata_o = '0;
    if (csr_access_i) begin
      if (cfg_hit) begin
        csr_rdata_o = {cfg_rd[{csr_addr_i[1:0], 2'd3}], cfg_rd[{csr_addr_i[1:0], 2'd2}],
                       cfg_rd[{csr_addr_i[1:0], 2'd1}], cfg_rd[{csr_addr_i[1:0], 2'd0}]};
      end else if (addr_hit) begin
        csr_rdata_o = addr_rd[csr_addr_i[3:0]];
      end else if (csr_addr_i == CSR_MSECCFG) begin
        csr_rdata_o = {29'b0, mseccfg_q};
      end
    end
  end

endmodule

// File: tb/tb_ibex_pmp_csr.sv
// Self-checking bench for ibex_pmp_csr: directed scenarios plus randomized traffic
// against a byte/word-level reference model of the PMP CSR rules.
module tb_ibex_pmp_csr;
  import ibex_pkg::*;

  localparam int N = 6;
  localparam int G = 2;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         csr_access_i;
  logic         csr_we_i;
  logic [11:0]  csr_addr_i;
  logic [31:0]  csr_wdata_i;
  logic [31:0]  csr_rdata_o;
  logic         csr_hit_o;
  pmp_cfg_t     csr_pmp_cfg_o [N];
  logic [33:0]  csr_pmp_addr_o [N];
  pmp_mseccfg_t csr_pmp_mseccfg_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  m_cfg  [16];
  logic [31:0] m_addr [16];
  bit          m_mml, m_mmwp, m_rlb;

  ibex_pmp_csr #(.PMPNumRegions(N), .PMPGranularity(G)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .csr_access_i     (csr_access_i),
    .csr_we_i         (csr_we_i),
    .csr_addr_i       (csr_addr_i),
    .csr_wdata_i      (csr_wdata_i),
    .csr_rdata_o      (csr_rdata_o),
    .csr_hit_o        (csr_hit_o),
    .csr_pmp_cfg_o    (csr_pmp_cfg_o),
    .csr_pmp_addr_o   (csr_pmp_addr_o),
    .csr_pmp_mseccfg_o(csr_pmp_mseccfg_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_cfg[i]  = 8'h00;
      m_addr[i] = 32'h0;
    end
    m_mml = 0; m_mmwp = 0; m_rlb = 0;
  endtask

  task automatic model_write(input logic [11:0] a, input logic [31:0] d);
    logic [7:0] b, nb, old;
    int r;
    bit lk, any_lock;
    if (a >= 12'h3A0 && a <= 12'h3A3) begin
      for (int i = 0; i < 4; i++) begin
        r = int'(a - 12'h3A0) * 4 + i;
        b = d[8*i +: 8];
        if (r >= N) continue;
        old = m_cfg[r];
        if (old[7] && !m_rlb) continue;
        if (m_mml && !m_rlb && b[7] && ((!b[0] && b[1]) || (b[2] && !(b[0] && b[1])))) continue;
        nb = b & 8'h9F;
        if (!m_mml && !b[0] && b[1]) nb[1] = 1'b0;
        if (G >= 1 && nb[4:3] == 2'b10) nb[4:3] = old[4:3];
        m_cfg[r] = nb;
      end
    end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
      r = int'(a - 12'h3B0);
      if (r < N) begin
        lk = m_cfg[r][7] || (r + 1 < N && m_cfg[r+1][4:3] == 2'b01 && m_cfg[r+1][7]);
        if (!(lk && !m_rlb)) m_addr[r] = d;
      end
    end else if (a == 12'h747) begin
      any_lock = 0;
      for (int i = 0; i < N; i++) if (m_cfg[i][7]) any_lock = 1;
      m_mml  = m_mml | d[0];
      m_mmwp = m_mmwp | d[1];
      m_rlb  = d[2] && (m_rlb || !any_lock);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    logic [31:0] v;
    int r;
    v = 32'h0;
    if (a >= 12'h3A0 && a <= 12'h3A3) begin
      r = int'(a - 12'h3A0) * 4;
      v = {m_cfg[r+3], m_cfg[r+2], m_cfg[r+1], m_cfg[r]};
    end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
      r = int'(a - 12'h3B0);
      v = m_addr[r];
      if (G >= 1 && m_cfg[r][4:3] == 2'b11) v = v | ((32'd1 << (G - 1)) - 32'd1);
      if (G >= 1 && m_cfg[r][4:3] <= 2'b01) v = v & ~((32'd1 << G) - 32'd1);
    end else if (a == 12'h747) begin
      v = {29'd0, m_rlb, m_mmwp, m_mml};
    end
    return v;
  endfunction

  function automatic bit model_hit(input logic [11:0] a);
    return (a >= 12'h3A0 && a <= 12'h3A3) || (a >= 12'h3B0 && a <= 12'h3BF) ||
           a == 12'h747 || a == 12'h757;
  endfunction

  function automatic logic [7:0] cfg_byte(input pmp_cfg_t c);
    return {c.lock, 2'b00, 2'(c.mode), c.exec, c.write, c.read};
  endfunction

  // ---------------- bus drivers ----------------
  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_access_i = 1; csr_we_i = 1; csr_addr_i = a; csr_wdata_i = d;
    @(posedge clk);
    model_write(a, d);
    #1;
    csr_access_i = 0; csr_we_i = 0;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d, output logic h);
    @(negedge clk);
    csr_access_i = 1; csr_we_i = 0; csr_addr_i = a;
    #1;
    d = csr_rdata_o;
    h = csr_hit_o;
    csr_access_i = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_i = 1;
    @(posedge clk);
    model_reset();
    #1;
    rst_i = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] rd; logic h;
    logic [11:0] alist [22];
    for (int i = 0; i < 4; i++)  alist[i] = 12'h3A0 + 12'(i);
    for (int i = 0; i < 16; i++) alist[4+i] = 12'h3B0 + 12'(i);
    alist[20] = 12'h747; alist[21] = 12'h757;
    apply_reset();
    for (int i = 0; i < 22; i++) begin
      csr_read(alist[i], rd, h);
      n_cmp++;
      if (rd !== 32'h0 || h !== 1'b1) begin
        n_err++;
        $display("FAIL reset_read[%h]: got data=%h hit=%b want data=0 hit=1", alist[i], rd, h);
      end
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (cfg_byte(csr_pmp_cfg_o[i]) !== 8'h00 || csr_pmp_addr_o[i] !== 34'h0) begin
        n_err++;
        $display("FAIL reset_port[%0d]: got cfg=%h addr=%h want 0", i, cfg_byte(csr_pmp_cfg_o[i]), csr_pmp_addr_o[i]);
      end
    end
    n_cmp++;
    if (csr_pmp_mseccfg_o !== 3'b000) begin
      n_err++;
      $display("FAIL reset_mseccfg: got %b want 000", csr_pmp_mseccfg_o);
    end
    csr_read(12'h3A4, rd, h);
    n_cmp++;
    if (rd !== 32'h0 || h !== 1'b0) begin
      n_err++;
      $display("FAIL miss_3A4: got data=%h hit=%b want data=0 hit=0", rd, h);
    end
  endtask

  task automatic test_cfg_lock();
    logic [31:0] rd; logic h;
    apply_reset();
    csr_write(12'h3A0, 32'h0000_009F);
    csr_read(12'h3A0, rd, h);
    n_cmp++;
    if (rd !== 32'h9F) begin n_err++; $display("FAIL cfg_lock_set: got %h want %h", rd, 32'h9F); end
    n_cmp++;
    if (csr_pmp_cfg_o[0].mode !== PMP_MODE_NAPOT || csr_pmp_cfg_o[0].lock !== 1'b1 ||
        csr_pmp_cfg_o[0].read !== 1'b1 || csr_pmp_cfg_o[0].write !== 1'b1 || csr_pmp_cfg_o[0].exec !== 1'b1) begin
      n_err++; $display("FAIL cfg_lock_port: got %h want 9f", cfg_byte(csr_pmp_cfg_o[0]));
    end
    csr_write(12'h3A0, 32'h0);
    csr_read(12'h3A0, rd, h);
    n_cmp++;
    if (rd !== 32'h9F) begin n_err++; $display("FAIL cfg_lock_hold: got %h want %h", rd, 32'h9F); end
  endtask

  task automatic test_tor_lock();
    logic [31:0] rd; logic h;
    apply_reset();
    csr_write(12'h3A0, 32'h0000_8800);
    csr_write(12'h3B0, 32'h1234);
    csr_read(12'h3B0, rd, h);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL tor_lock_addr: got %h want 0", rd); end
    apply_reset();
    csr_write(12'h747, 32'h4);
    csr_read(12'h747, rd, h);
    n_cmp++;
    if (rd !== 32'h4) begin n_err++; $display("FAIL rlb_set: got %h want 4", rd); end
    csr_write(12'h3A0, 32'h0000_8800);
    csr_write(12'h3B0, 32'h1234);
    csr_read(12'h3B0, rd, h);
    n_cmp++;
    if (rd !== 32'h1234) begin n_err++; $display("FAIL rlb_addr: got %h want 1234", rd); end
    n_cmp++;
    if (csr_pmp_addr_o[0] !== 34'h48D0) begin
      n_err++; $display("FAIL rlb_addr_port: got %h want 48d0", csr_pmp_addr_o[0]);
    end
  endtask

  task automatic test_mml();
    logic [31:0] rd; logic h;
    logic [7:0] wv [4]; logic [7:0] ev [4];
    apply_reset();
    csr_write(12'h3A0, 32'h02);
    csr_read(12'h3A0, rd, h);
    n_cmp++;
    if (rd !== 32'h00) begin n_err++; $display("FAIL mml0_rw: got %h want 0", rd); end
    csr_write(12'h747, 32'h1);
    wv[0] = 8'h02; ev[0] = 8'h02;
    wv[1] = 8'h82; ev[1] = 8'h02;
    wv[2] = 8'h84; ev[2] = 8'h02;
    wv[3] = 8'h87; ev[3] = 8'h87;
    for (int i = 0; i < 4; i++) begin
      csr_write(12'h3A0, {24'h0, wv[i]});
      csr_read(12'h3A0, rd, h);
      n_cmp++;
      if (rd !== {24'h0, ev[i]}) begin
        n_err++; $display("FAIL mml1_cfg[%h]: got %h want %h", wv[i], rd, ev[i]);
      end
    end
  endtask

  task automatic test_mseccfg();
    logic [31:0] rd; logic h;
    apply_reset();
    csr_write(12'h747, 32'h3);
    csr_write(12'h747, 32'h0);
    csr_read(12'h747, rd, h);
    n_cmp++;
    if (rd !== 32'h3) begin n_err++; $display("FAIL msec_sticky: got %h want 3", rd); end
    csr_write(12'h757, 32'hFFFF_FFFF);
    csr_read(12'h757, rd, h);
    n_cmp++;
    if (rd !== 32'h0 || h !== 1'b1) begin n_err++; $display("FAIL mseccfgh: got %h hit=%b want 0 hit=1", rd, h); end
    apply_reset();
    csr_read(12'h747, rd, h);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL msec_reset: got %h want 0", rd); end
    csr_write(12'h747, 32'h4);
    csr_write(12'h747, 32'h0);
    csr_read(12'h747, rd, h);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL rlb_clear: got %h want 0", rd); end
    csr_write(12'h3A1, 32'h0000_8000);
    csr_write(12'h747, 32'h4);
    csr_read(12'h747, rd, h);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL rlb_denied: got %h want 0", rd); end
  endtask

  task automatic test_granularity();
    logic [31:0] rd; logic h;
    apply_reset();
    csr_write(12'h3B0, 32'h0);
    csr_write(12'h3A0, 32'h18);
    csr_read(12'h3B0, rd, h);
    n_cmp++;
    if (rd !== 32'h1) begin n_err++; $display("FAIL gran_napot: got %h want 1", rd); end
    csr_write(12'h3A0, 32'h00);
    csr_write(12'h3B0, 32'hF);
    csr_read(12'h3B0, rd, h);
    n_cmp++;
    if (rd !== 32'hC) begin n_err++; $display("FAIL gran_off: got %h want c", rd); end
    n_cmp++;
    if (csr_pmp_addr_o[0] !== 34'h3C) begin n_err++; $display("FAIL gran_port: got %h want 3c", csr_pmp_addr_o[0]); end
    csr_write(12'h3A0, 32'h11);
    csr_read(12'h3A0, rd, h);
    n_cmp++;
    if (rd !== 32'h01) begin n_err++; $display("FAIL na4_keep_off: got %h want 1", rd); end
    csr_write(12'h3A0, 32'h18);
    csr_write(12'h3A0, 32'h13);
    csr_read(12'h3A0, rd, h);
    n_cmp++;
    if (rd !== 32'h1B) begin n_err++; $display("FAIL na4_keep_napot: got %h want 1b", rd); end
  endtask

  task automatic test_unimpl();
    logic [31:0] rd; logic h;
    apply_reset();
    csr_write(12'h3A1, 32'hFFFF_FFFF);
    csr_read(12'h3A1, rd, h);
    n_cmp++;
    if (rd !== 32'h0000_9F9F) begin n_err++; $display("FAIL unimpl_cfg1: got %h want 9f9f", rd); end
    csr_write(12'h3A2, 32'hFFFF_FFFF);
    csr_read(12'h3A2, rd, h);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL unimpl_cfg2: got %h want 0", rd); end
    csr_write(12'h3B8, 32'hFFFF_FFFF);
    csr_read(12'h3B8, rd, h);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL unimpl_addr8: got %h want 0", rd); end
    csr_write(12'h3B5, 32'hFFFF_FFFF);
    csr_read(12'h3B5, rd, h);
    n_cmp++;
    if (rd !== 32'h1) begin n_err++; $display("FAIL locked_addr5: got %h want 1", rd); end
  endtask

  task automatic test_reset_collision();
    logic [31:0] rd; logic h;
    apply_reset();
    csr_write(12'h3B1, 32'h5550);
    @(negedge clk);
    rst_i = 1; csr_access_i = 1; csr_we_i = 1; csr_addr_i = 12'h3B1; csr_wdata_i = 32'hFFFF;
    @(posedge clk);
    model_reset();
    #1;
    rst_i = 0; csr_access_i = 0; csr_we_i = 0;
    csr_read(12'h3B1, rd, h);
    n_cmp++;
    if (rd !== 32'h0) begin n_err++; $display("FAIL rst_collision: got %h want 0", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [N];
    apply_reset();
    for (int i = 0; i < N; i++) begin
      d[i] = $urandom;
      csr_write(12'h3B0 + 12'(i), d[i]);
      n_cmp++;
      if (csr_pmp_addr_o[i] !== {d[i], 2'b00}) begin
        n_err++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, csr_pmp_addr_o[i], {d[i], 2'b00});
      end
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (csr_pmp_addr_o[i] !== {m_addr[i], 2'b00}) begin
        n_err++; $display("FAIL b2b_hold[%0d]: got %h want %h", i, csr_pmp_addr_o[i], {m_addr[i], 2'b00});
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, d; logic h; logic [11:0] a;
    int sel;
    apply_reset();
    for (int it = 0; it < 400; it++) begin
      sel = int'($urandom_range(0, 99));
      case ($urandom_range(0, 9))
        0, 1, 2: a = 12'h3A0 + 12'($urandom_range(0, 3));
        3, 4, 5, 6: a = 12'h3B0 + 12'($urandom_range(0, 15));
        7: a = ($urandom_range(0, 1) == 0) ? 12'h747 : 12'h757;
        default: a = 12'($urandom);
      endcase
      d = $urandom;
      if (sel < 3) begin
        apply_reset();
      end else if (sel < 45) begin
        if (a == 12'h747 && $urandom_range(0, 3) != 0) a = 12'h3B0;
        csr_write(a, d);
      end else if (sel < 90) begin
        csr_read(a, rd, h);
        n_cmp++;
        if (rd !== model_read(a) || h !== model_hit(a)) begin
          n_err++;
          $display("FAIL rand_read[%h]: got data=%h hit=%b want data=%h hit=%b", a, rd, h, model_read(a), model_hit(a));
        end
      end else begin
        @(negedge clk);
        csr_access_i = 0; csr_we_i = 1; csr_addr_i = a; csr_wdata_i = d;
        #1;
        n_cmp++;
        if (csr_rdata_o !== 32'h0) begin
          n_err++; $display("FAIL rand_noaccess[%h]: got %h want 0", a, csr_rdata_o);
        end
        @(posedge clk);
        #1;
        csr_we_i = 0;
      end
      if (it % 8 == 0) begin
        for (int r = 0; r < N; r++) begin
          n_cmp++;
          if (cfg_byte(csr_pmp_cfg_o[r]) !== m_cfg[r] || csr_pmp_addr_o[r] !== {m_addr[r], 2'b00}) begin
            n_err++;
            $display("FAIL rand_port[%0d]: got cfg=%h addr=%h want cfg=%h addr=%h", r,
                     cfg_byte(csr_pmp_cfg_o[r]), csr_pmp_addr_o[r], m_cfg[r], {m_addr[r], 2'b00});
          end
        end
        n_cmp++;
        if (csr_pmp_mseccfg_o !== {m_rlb, m_mmwp, m_mml}) begin
          n_err++; $display("FAIL rand_mseccfg: got %b want %b", csr_pmp_mseccfg_o, {m_rlb, m_mmwp, m_mml});
        end
      end
    end
  endtask

  initial begin
    rst_i = 1; csr_access_i = 0; csr_we_i = 0; csr_addr_i = '0; csr_wdata_i = '0;
    model_reset();
    test_reset();
    test_cfg_lock();
    test_tor_lock();
    test_mml();
    test_mseccfg();
    test_granularity();
    test_unimpl();
    test_reset_collision();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
